bus_slave_mux_tmo: RTL and testbench
====================================

Name: bus_slave_mux_tmo

Overview:
- Parametrised, registered read-response multiplexer between N bus slaves and the bus master.
- Tracks each transaction from chip-select to ready. Returns the selected slave's read data and ready one cycle later.
- A watchdog terminates transactions that a slave never acknowledges, and reports the timeout as an error.
- Flags multiple simultaneous chip-selects. Sits after the address decoder, in place of the fixed 8-slave combinational mux.

Parameters:
- NUM_SLAVES, 8, number of slave channels (2..16).
- DATA_W, 32, read data width.
- SEL_W, 3, width of the slave index; must be at least ceil(log2(NUM_SLAVES)).
- TMO_W, 8, watchdog counter width.
- TMO_CYCLES, 255, cycles spent waiting in WAIT before timeout (1..2^TMO_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_cs_  in  NUM_SLAVES  per-slave chip select, active low, from the address decoder.
- s_rd_data  in  NUM_SLAVES*DATA_W  slave read data, packed; slave i occupies bits [i*DATA_W +: DATA_W].
- s_rdy_  in  NUM_SLAVES  per-slave ready, active low.
- m_rd_data  out  DATA_W  registered read data to the master.
- m_rdy_  out  1  registered ready to the master, active low, one-cycle pulse.
- m_err  out  1  registered; high together with the m_rdy_ pulse when the transaction timed out.
- multi_cs_err  out  1  sticky flag: more than one s_cs_ was low at transaction start; cleared only by reset.
- busy  out  1  high in states WAIT and HOLD.
- cur_sel  out  SEL_W  index of the latched slave; valid while busy.

Behaviour:
- Reset (asynchronous, active-high) forces all of the following, from any state including mid-transaction:
  - state IDLE;
  - m_rd_data = 0, m_rdy_ = 1, m_err = 0;
  - multi_cs_err = 0, busy = 0, cur_sel = 0;
  - watchdog count = 0.
- Selection priority: the lowest index with s_cs_ low wins.
- IDLE:
  - If any s_cs_ bit is low: latch cur_sel = winning index, clear the count, go to WAIT.
  - If two or more bits are low in that same cycle, set multi_cs_err = 1 (sticky).
  - No selection: stay in IDLE.
- WAIT, evaluated every cycle in this order:
  - a) s_cs_[cur_sel] high (master withdrew): go to IDLE. No m_rdy_ pulse, no error.
  - b) s_rdy_[cur_sel] low: register m_rd_data = slave data for cur_sel, m_rdy_ = 0, m_err = 0; go to HOLD.
  - c) count == TMO_CYCLES-1: register m_rd_data = 0, m_rdy_ = 0, m_err = 1; go to HOLD.
  - d) otherwise: count += 1; no wrap is possible, because c) fires first.
- Ready and timeout in the same cycle: ready wins (b before c).
- Latency:
  - Slave ready sampled low at edge N gives m_rdy_ low during cycle N+1 (exactly one cycle).
  - Minimum transaction: cs in cycle 0, rdy in cycle 1, m_rdy_ in cycle 2.
- HOLD:
  - m_rdy_ returns to 1 and m_err to 0 after the single pulse cycle.
  - m_rd_data holds its value until the next response.
  - Stays in HOLD while s_cs_[cur_sel] is low, so a held chip-select does not re-trigger. Goes to IDLE when it goes high.
  - Chip-selects of other slaves are ignored in HOLD.
- Changes on non-selected channels during WAIT are ignored; only multi_cs_err records them, and only at the start edge.
- Timeout count: ready is sampled on each of TMO_CYCLES consecutive WAIT cycles; the error pulse follows on the next cycle.

Test Plan:
- Single read: s_cs_[3] low at cycle 0; s_rdy_[3] low at cycle 2 with data 0xDEADBEEF -> m_rdy_=0 and m_rd_data=0xDEADBEEF in cycle 3 only; m_err=0; busy falls the cycle after cs_ rises.
- Priority and multi-select: s_cs_[1] and s_cs_[5] low together; both slaves ready with different data -> slave 1 data returned; cur_sel=1; multi_cs_err=1, and it stays 1 after the transaction ends.
- Timeout: TMO_CYCLES=4; s_cs_[0] held low, s_rdy_ never asserted -> m_rdy_=0, m_err=1, m_rd_data=0 in cycle 5; state HOLD until cs_ rises.
- Ready on the timeout boundary: s_rdy_ low exactly in the 4th WAIT cycle -> normal response with m_err=0.
- Abort and held cs: s_cs_[2] released in WAIT -> no m_rdy_ pulse, back to IDLE. Separately, cs held for 10 cycles after a response -> only one m_rdy_ pulse.
- Asynchronous reset asserted mid-WAIT -> all outputs reach their reset values without waiting for a clock edge; after release, a new read completes normally.

Source files
------------

// File: rtl/bus_slave_mux_tmo_if.sv
// Bus bundle between the slave channels, the response mux and the bus master.
// The slave modport is the mux's view; the master modport is the view of whatever drives the slaves.
interface bus_slave_mux_tmo_if #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 3
);
    logic [NUM_SLAVES-1:0]        s_cs_;
    logic [NUM_SLAVES*DATA_W-1:0] s_rd_data;
    logic [NUM_SLAVES-1:0]        s_rdy_;
    logic [DATA_W-1:0]            m_rd_data;
    logic                         m_rdy_;
    logic                         m_err;
    logic                         multi_cs_err;
    logic                         busy;
    logic [SEL_W-1:0]             cur_sel;

    modport slave (
        input  s_cs_, s_rd_data, s_rdy_,
        output m_rd_data, m_rdy_, m_err, multi_cs_err, busy, cur_sel
    );

    modport master (
        output s_cs_, s_rd_data, s_rdy_,
        input  m_rd_data, m_rdy_, m_err, multi_cs_err, busy, cur_sel
    );
endinterface

// File: rtl/bus_slave_mux_tmo.sv
// Registered read-response mux for N slaves. It latches the lowest selected slave,
// waits for its ready, and answers with an error pulse when a watchdog expires first.
module bus_slave_mux_tmo #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned TMO_W      = 8,
    parameter int unsigned TMO_CYCLES = 255
) (
    input logic                clk,
    input logic                reset,
    bus_slave_mux_tmo_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    localparam logic [TMO_W-1:0]      TmoLast = TMO_W'(TMO_CYCLES - 1);
    localparam logic [NUM_SLAVES-1:0] One     = NUM_SLAVES'(1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cur_sel_q, cur_sel_d;
    logic [TMO_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rdy_n_q, rdy_n_d;
    logic                err_q, err_d;
    logic                multi_q, multi_d;

    logic [NUM_SLAVES-1:0] cs_low;
    logic                  any_sel;
    logic                  multi_sel;
    logic [SEL_W-1:0]      win_idx;
    logic [DATA_W-1:0]     sel_data;

    assign cs_low    = ~bus.s_cs_;
    assign any_sel   = |cs_low;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_sel = |(cs_low & (cs_low - One));
    assign sel_data  = bus.s_rd_data[cur_sel_q*DATA_W +: DATA_W];

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (cs_low[i]) begin
                win_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        rdy_n_d   = 1'b1;
        err_d     = 1'b0;
        multi_d   = multi_q;
        unique case (state_q)
            StIdle: begin
                if (any_sel) begin
                    cur_sel_d = win_idx;
                    count_d   = '0;
                    state_d   = StWait;
                    if (multi_sel) begin
                        multi_d = 1'b1;
                    end
                end
            end
            StWait: begin
                if (bus.s_cs_[cur_sel_q]) begin
                    state_d = StIdle;
                end else if (!bus.s_rdy_[cur_sel_q]) begin
                    rd_data_d = sel_data;
                    rdy_n_d   = 1'b0;
                    state_d   = StHold;
                end else if (count_q == TmoLast) begin
                    rd_data_d = '0;
                    rdy_n_d   = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StHold;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            StHold: begin
                // A chip-select held past the response must not start a second transaction.
                if (bus.s_cs_[cur_sel_q]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cur_sel_q <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
            rdy_n_q   <= 1'b1;
            err_q     <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
            rdy_n_q   <= rdy_n_d;
            err_q     <= err_d;
            multi_q   <= multi_d;
        end
    end

    assign bus.m_rd_data    = rd_data_q;
    assign bus.m_rdy_       = rdy_n_q;
    assign bus.m_err        = err_q;
    assign bus.multi_cs_err = multi_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.cur_sel      = cur_sel_q;

endmodule

// File: tb/tb_bus_slave_mux_tmo.sv
// Bench for bus_slave_mux_tmo: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model.
module tb_bus_slave_mux_tmo;

    localparam int NS  = 8;
    localparam int DW  = 32;
    localparam int SW  = 3;
    localparam int TMO = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    bus_slave_mux_tmo_if #(.NUM_SLAVES(NS), .DATA_W(DW), .SEL_W(SW)) bus ();

    bus_slave_mux_tmo #(
        .NUM_SLAVES(NS),
        .DATA_W    (DW),
        .SEL_W     (SW),
        .TMO_W     (8),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: is a transaction open, which slave, how many ready
    // samples it has seen, and whether it has already been answered.
    bit          e_busy, e_held, e_rdy_n, e_err, e_multi;
    int          e_sel, e_waited, lows, first;
    logic [31:0] e_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_busy = 0; e_held = 0; e_sel = 0; e_waited = 0;
            e_data = '0; e_rdy_n = 1; e_err = 0; e_multi = 0;
        end else begin
            e_rdy_n = 1;
            e_err   = 0;
            if (!e_busy) begin
                lows  = 0;
                first = -1;
                for (int i = 0; i < NS; i++) begin
                    if (!bus.s_cs_[i]) begin
                        lows++;
                        if (first < 0) first = i;
                    end
                end
                if (first >= 0) begin
                    e_busy = 1; e_held = 0; e_sel = first; e_waited = 0;
                    if (lows > 1) e_multi = 1;
                end
            end else if (bus.s_cs_[e_sel]) begin
                e_busy = 0;
            end else if (!e_held) begin
                e_waited++;
                if (!bus.s_rdy_[e_sel]) begin
                    e_data = bus.s_rd_data[e_sel*DW +: DW];
                    e_rdy_n = 0; e_held = 1;
                end else if (e_waited == TMO) begin
                    e_data = '0; e_rdy_n = 0; e_err = 1; e_held = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_rdy_", bus.m_rdy_, e_rdy_n);
        chk("m_err", bus.m_err, e_err);
        chk("m_rd_data", bus.m_rd_data, e_data);
        chk("busy", bus.busy, e_busy);
        chk("multi_cs_err", bus.multi_cs_err, e_multi);
        if (e_busy) chk("cur_sel", bus.cur_sel, e_sel);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_all();
        bus.s_cs_  = '1;
        bus.s_rdy_ = '1;
    endtask

    int pulses;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        bus.s_cs_ = '1;
        bus.s_rdy_ = '1;
        bus.s_rd_data = '0;
        reset = 1'b1;
        #3;
        chk("rst_m_rdy_", bus.m_rdy_, 1);
        chk("rst_m_err", bus.m_err, 0);
        chk("rst_data", bus.m_rd_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_multi", bus.multi_cs_err, 0);
        chk("rst_cur_sel", bus.cur_sel, 0);
        #9 reset = 1'b0;
        tick();

        // Single read on slave 3, ready two cycles after select.
        bus.s_cs_[3] = 1'b0;
        tick();
        chk("rd_c1_busy", bus.busy, 1);
        chk("rd_c1_sel", bus.cur_sel, 3);
        tick();
        chk("rd_c2_rdy", bus.m_rdy_, 1);
        bus.s_rdy_[3] = 1'b0;
        bus.s_rd_data[3*DW +: DW] = 32'hDEADBEEF;
        tick();
        chk("rd_c3_rdy", bus.m_rdy_, 0);
        chk("rd_c3_data", bus.m_rd_data, 32'hDEADBEEF);
        chk("rd_c3_err", bus.m_err, 0);
        bus.s_rdy_[3] = 1'b1;
        tick();
        chk("rd_c4_rdy", bus.m_rdy_, 1);
        chk("rd_c4_data", bus.m_rd_data, 32'hDEADBEEF);
        chk("rd_c4_busy", bus.busy, 1);
        bus.s_cs_[3] = 1'b1;
        tick();
        chk("rd_c5_busy", bus.busy, 0);
        chk("rd_c5_multi", bus.multi_cs_err, 0);

        // Two selects together: lowest index wins, sticky multi flag.
        bus.s_cs_[1] = 1'b0; bus.s_cs_[5] = 1'b0;
        bus.s_rdy_[1] = 1'b0; bus.s_rdy_[5] = 1'b0;
        bus.s_rd_data[1*DW +: DW] = 32'h11111111;
        bus.s_rd_data[5*DW +: DW] = 32'h55555555;
        tick();
        chk("mc_sel", bus.cur_sel, 1);
        chk("mc_multi", bus.multi_cs_err, 1);
        tick();
        chk("mc_rdy", bus.m_rdy_, 0);
        chk("mc_data", bus.m_rd_data, 32'h11111111);
        release_all();
        tick();
        chk("mc_busy_end", bus.busy, 0);
        chk("mc_multi_sticky", bus.multi_cs_err, 1);
        tick();

        // Watchdog: slave 0 never answers.
        bus.s_cs_[0] = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            tick();
            chk("to_wait_rdy", bus.m_rdy_, 1);
        end
        tick();
        chk("to_rdy", bus.m_rdy_, 0);
        chk("to_err", bus.m_err, 1);
        chk("to_data", bus.m_rd_data, 0);
        tick();
        chk("to_after_rdy", bus.m_rdy_, 1);
        chk("to_after_err", bus.m_err, 0);
        tick();
        chk("to_hold_busy", bus.busy, 1);
        release_all();
        tick();
        chk("to_idle", bus.busy, 0);

        // Ready in the last WAIT cycle beats the timeout.
        bus.s_cs_[0] = 1'b0;
        tick(); tick(); tick(); tick();
        bus.s_rdy_[0] = 1'b0;
        bus.s_rd_data[0*DW +: DW] = 32'hCAFEF00D;
        tick();
        chk("bd_rdy", bus.m_rdy_, 0);
        chk("bd_err", bus.m_err, 0);
        chk("bd_data", bus.m_rd_data, 32'hCAFEF00D);
        release_all();
        tick(); tick();

        // Master withdraws during WAIT.
        bus.s_cs_[2] = 1'b0;
        tick();
        chk("ab_sel", bus.cur_sel, 2);
        bus.s_cs_[2] = 1'b1;
        tick();
        chk("ab_busy", bus.busy, 0);
        chk("ab_rdy", bus.m_rdy_, 1);
        tick();
        chk("ab_rdy2", bus.m_rdy_, 1);

        // Chip-select and ready held long after the response: one pulse only.
        bus.s_cs_[4] = 1'b0;
        bus.s_rdy_[4] = 1'b0;
        bus.s_rd_data[4*DW +: DW] = 32'hA5A5_0404;
        pulses = 0;
        repeat (12) begin
            tick();
            if (bus.m_rdy_ === 1'b0) pulses++;
        end
        chk("held_pulses", pulses, 1);
        release_all();
        tick(); tick();

        // Asynchronous reset in the middle of WAIT.
        bus.s_cs_[6] = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        chk("ar_rdy", bus.m_rdy_, 1);
        chk("ar_err", bus.m_err, 0);
        chk("ar_data", bus.m_rd_data, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_multi", bus.multi_cs_err, 0);
        chk("ar_sel", bus.cur_sel, 0);
        release_all();
        #3 reset = 1'b0;
        tick();
        bus.s_cs_[7] = 1'b0;
        bus.s_rdy_[7] = 1'b0;
        bus.s_rd_data[7*DW +: DW] = 32'h12345678;
        tick(); tick();
        chk("ar_new_rdy", bus.m_rdy_, 0);
        chk("ar_new_data", bus.m_rd_data, 32'h12345678);
        chk("ar_new_sel", bus.cur_sel, 7);
        release_all();
        tick(); tick();

        // Random episodes of select patterns with random ready and data.
        for (int ep = 0; ep < 400; ep++) begin
            int mode;
            logic [NS-1:0] cs;
            mode = int'($urandom_range(0, 3));
            cs = '1;
            if (mode == 1) begin
                cs[$urandom_range(0, NS - 1)] = 1'b0;
            end else if (mode == 2) begin
                cs[$urandom_range(0, NS - 1)] = 1'b0;
                cs[$urandom_range(0, NS - 1)] = 1'b0;
            end else if (mode == 3) begin
                cs = NS'($urandom);
            end
            bus.s_cs_ = cs;
            repeat ($urandom_range(1, 10)) begin
                bus.s_rdy_ = NS'($urandom) | NS'($urandom);
                for (int i = 0; i < NS; i++) bus.s_rd_data[i*DW +: DW] = $urandom;
                tick();
            end
        end
        release_all();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
